// File: rtl/hazard_unit6.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit6
//  Description : Stall/flush/forward control for a six-stage pipeline
//                (F D E B M W) with a shadow copy of downstream register
//                fields and saturating stall/redirect counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit6 #(
    parameter logic [2:0] LOAD_SRC = 3'b001,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [2:0]       ResultSrcD,
    input  logic             PCSrcB0,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushB,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [4:0]       r_Rs1E, r_Rs2E, r_RdE, r_RdB, r_RdM, r_RdW;
    logic             r_RegWriteE, r_RegWriteB, r_RegWriteM, r_RegWriteW;
    logic             r_LoadE, r_LoadB, r_LoadM;
    logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

    logic w_loadD, w_hitE, w_hitB, w_lwStall;

    // Loads in B or M have no value yet on the bypass network, so they are skipped.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdB, input logic rwB, input logic ldB,
        input logic [4:0] rdM, input logic rwM, input logic ldM,
        input logic [4:0] rdW, input logic rwW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (rwB && !ldB && rdB == rs)      sel = 2'b11;
            else if (rwM && !ldM && rdM == rs) sel = 2'b10;
            else if (rwW && rdW == rs)         sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_loadD   = (ResultSrcD == LOAD_SRC);
    assign w_hitE    = r_LoadE & r_RegWriteE & (r_RdE != 5'd0) &
                       ((r_RdE == Rs1D) | (r_RdE == Rs2D));
    assign w_hitB    = r_LoadB & r_RegWriteB & (r_RdB != 5'd0) &
                       ((r_RdB == Rs1D) | (r_RdB == Rs2D));
    assign w_lwStall = w_hitE | w_hitB;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushB    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        if (!reset) begin
            // A taken redirect overrides a load-use stall; FlushB kills the wrong-path load.
            StallF    = w_lwStall & ~PCSrcB0;
            StallD    = w_lwStall & ~PCSrcB0;
            FlushD    = PCSrcB0;
            FlushE    = PCSrcB0 | w_lwStall;
            FlushB    = PCSrcB0;
            ForwardAE = fwdSel(r_Rs1E, r_RdB, r_RegWriteB, r_LoadB,
                               r_RdM, r_RegWriteM, r_LoadM, r_RdW, r_RegWriteW);
            ForwardBE = fwdSel(r_Rs2E, r_RdB, r_RegWriteB, r_LoadB,
                               r_RdM, r_RegWriteM, r_LoadM, r_RdW, r_RegWriteW);
            ForwardAD = r_RegWriteW & (r_RdW != 5'd0) & (r_RdW == Rs1D);
            ForwardBD = r_RegWriteW & (r_RdW != 5'd0) & (r_RdW == Rs2D);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_Rs1E      <= '0;
            r_Rs2E      <= '0;
            r_RdE       <= '0;
            r_RegWriteE <= 1'b0;
            r_LoadE     <= 1'b0;
            r_RdB       <= '0;
            r_RegWriteB <= 1'b0;
            r_LoadB     <= 1'b0;
            r_RdM       <= '0;
            r_RegWriteM <= 1'b0;
            r_LoadM     <= 1'b0;
            r_RdW       <= '0;
            r_RegWriteW <= 1'b0;
            r_stallCnt  <= '0;
            r_flushCnt  <= '0;
        end else begin
            if (FlushE) begin
                r_Rs1E      <= '0;
                r_Rs2E      <= '0;
                r_RdE       <= '0;
                r_RegWriteE <= 1'b0;
                r_LoadE     <= 1'b0;
            end else begin
                r_Rs1E      <= Rs1D;
                r_Rs2E      <= Rs2D;
                r_RdE       <= RdD;
                r_RegWriteE <= RegWriteD;
                r_LoadE     <= w_loadD;
            end
            if (FlushB) begin
                r_RdB       <= '0;
                r_RegWriteB <= 1'b0;
                r_LoadB     <= 1'b0;
            end else begin
                r_RdB       <= r_RdE;
                r_RegWriteB <= r_RegWriteE;
                r_LoadB     <= r_LoadE;
            end
            r_RdM       <= r_RdB;
            r_RegWriteM <= r_RegWriteB;
            r_LoadM     <= r_LoadB;
            r_RdW       <= r_RdM;
            r_RegWriteW <= r_RegWriteM;
            if (StallD && r_stallCnt != c_CNT_MAX)
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (PCSrcB0 && r_flushCnt != c_CNT_MAX)
                r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign StallCnt = r_stallCnt;
    assign FlushCnt = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit6.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit6
//  Description : Randomized + directed scoreboard bench for hazard_unit6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit6;

    localparam int         CNT_W = 8;
    localparam logic [2:0] LD    = 3'b001;
    localparam int         CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       Rs1D = '0, Rs2D = '0, RdD = '0;
    logic             RegWriteD = 1'b0;
    logic [2:0]       ResultSrcD = '0;
    logic             PCSrcB0 = 1'b0;
    logic             StallF, StallD, FlushD, FlushE, FlushB;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    hazard_unit6 #(.LOAD_SRC(LD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcB0(PCSrcB0),
        .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .FlushB(FlushB),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld;
    } instr_t;

    typedef struct packed {
        logic             stallF, stallD, flushD, flushE, flushB;
        logic [1:0]       fAE, fBE;
        logic             fAD, fBD;
        logic [CNT_W-1:0] sCnt, fCnt;
    } exp_t;

    int     nChecks = 0;
    int     nErrors = 0;
    exp_t   q[$];

    // Reference model: instruction records flowing through E, B, M, W (index 0..3).
    instr_t stg[4];
    int     mStall = 0, mFlush = 0;
    logic   lastRst = 1'b1;
    logic   lastPc  = 1'b0;
    instr_t lastD   = '0;
    exp_t   lastExp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] fwdExp(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        for (int s = 1; s <= 3; s++)
            if (stg[s].rw && stg[s].rd == r && (s == 3 || !stg[s].ld))
                return 2'(4 - s);
        return 2'b00;
    endfunction

    task automatic advance();
        if (lastRst) begin
            for (int s = 0; s < 4; s++) stg[s] = '0;
            mStall = 0;
            mFlush = 0;
        end else begin
            if (lastExp.stallD && mStall < CMAX) mStall++;
            if (lastPc && mFlush < CMAX) mFlush++;
            stg[3] = stg[2];
            stg[2] = stg[1];
            stg[1] = lastExp.flushB ? '0 : stg[0];
            stg[0] = lastExp.flushE ? '0 : lastD;
        end
    endtask

    task automatic cyc(input logic rst, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic rw, input logic [2:0] src,
                       input logic pc);
        exp_t e;
        logic haz;
        @(posedge clk);
        #1;
        advance();
        reset = rst; Rs1D = a; Rs2D = b; RdD = d;
        RegWriteD = rw; ResultSrcD = src; PCSrcB0 = pc;
        e = '0;
        if (rst) begin
            e.flushD = 1'b1; e.flushE = 1'b1; e.flushB = 1'b1;
        end else begin
            haz = 1'b0;
            for (int s = 0; s < 2; s++)
                if (stg[s].ld && stg[s].rw && stg[s].rd != 5'd0 &&
                    (stg[s].rd == a || stg[s].rd == b))
                    haz = 1'b1;
            e.stallF = haz & ~pc;
            e.stallD = haz & ~pc;
            e.flushD = pc;
            e.flushB = pc;
            e.flushE = pc | haz;
            e.fAE = fwdExp(stg[0].rs1);
            e.fBE = fwdExp(stg[0].rs2);
            e.fAD = stg[3].rw && stg[3].rd != 5'd0 && stg[3].rd == a;
            e.fBD = stg[3].rw && stg[3].rd != 5'd0 && stg[3].rd == b;
        end
        e.sCnt = CNT_W'(mStall);
        e.fCnt = CNT_W'(mFlush);
        q.push_back(e);
        lastExp = e;
        lastRst = rst;
        lastPc  = pc;
        lastD   = '{rs1: a, rs2: b, rd: d, rw: rw, ld: (src == LD)};
    endtask

    task automatic nop();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic rst2();
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0);
    endtask

    // Hold the consumer in D while the DUT stalls, as a real F/D register would.
    task automatic issueHold(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             output int nStall);
        nStall = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, a, b, d, 1'b1, 3'd0, 1'b0);
            #2;
            if (StallD === 1'b1) nStall++;
            else break;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{stallF: StallF, stallD: StallD, flushD: FlushD, flushE: FlushE,
                  flushB: FlushB, fAE: ForwardAE, fBE: ForwardBE, fAD: ForwardAD,
                  fBD: ForwardBD, sCnt: StallCnt, fCnt: FlushCnt};
            nChecks++;
            if (a !== e) begin
                nErrors++;
                $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, a, e);
            end
        end
    end

    initial begin
        int n;
        logic [1:0] gapCode [3];
        gapCode[0] = 2'b11; gapCode[1] = 2'b10; gapCode[2] = 2'b01;

        rst2();
        #2;
        chk("reset_outputs", {StallF, StallD, FlushD, FlushE, FlushB,
                              ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 32'h1C0);

        // lw x5 ; add x6,x5,x7
        nop();
        cyc(1'b0, 5'd1, 5'd0, 5'd5, 1'b1, LD, 1'b0);
        issueHold(5'd5, 5'd7, 5'd6, n);
        chk("lwE_stall_cycles", n, 2);
        nop(); #2;
        chk("lwE_fwdAE", ForwardAE, 2'b01);
        chk("lwE_stallCnt", StallCnt, 2);

        // lw x5 ; addi x9,x1 ; add x6,x5,x5
        rst2();
        cyc(1'b0, 5'd1, 5'd0, 5'd5, 1'b1, LD, 1'b0);
        cyc(1'b0, 5'd1, 5'd0, 5'd9, 1'b1, 3'd0, 1'b0);
        issueHold(5'd5, 5'd5, 5'd6, n);
        chk("lwB_stall_cycles", n, 1);
        nop(); #2;
        chk("lwB_fwdAB", {ForwardAE, ForwardBE}, 4'b0101);

        // ALU producer then consumer with 0..3 gaps
        for (int g = 0; g < 4; g++) begin
            rst2();
            cyc(1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 3'd0, 1'b0);
            repeat (g) nop();
            cyc(1'b0, 5'd5, 5'd6, 5'd7, 1'b1, 3'd0, 1'b0);
            #2;
            chk("alu_no_stall", StallD, 1'b0);
            if (g == 3) begin
                chk("alu_gap3_fwdAD", ForwardAD, 1'b1);
            end else begin
                nop(); #2;
                chk("alu_gap_fwdAE", ForwardAE, gapCode[g]);
            end
        end

        // x0 is never forwarded
        rst2();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 3'd0, 1'b0);
        #2; chk("x0_no_stall", StallD, 1'b0);
        nop(); #2;
        chk("x0_fwd", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 6'd0);

        // redirect wins over load-use
        rst2();
        cyc(1'b0, 5'd1, 5'd0, 5'd5, 1'b1, LD, 1'b0);
        cyc(1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 3'd0, 1'b1);
        #2; chk("redir_ctl", {StallD, FlushD, FlushE, FlushB}, 4'b0111);
        nop(); #2;
        chk("redir_next_stall", StallD, 1'b0);
        chk("redir_flushCnt", FlushCnt, 1);

        // reset during a stall
        rst2();
        cyc(1'b0, 5'd1, 5'd0, 5'd5, 1'b1, LD, 1'b0);
        cyc(1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 3'd0, 1'b0);
        #2; chk("rstmid_stall_seen", StallD, 1'b1);
        cyc(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 3'd0, 1'b0);
        cyc(1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 3'd0, 1'b0);
        #2;
        chk("rstmid_stall", StallD, 1'b0);
        chk("rstmid_cnts", {StallCnt, FlushCnt}, 0);
        chk("rstmid_fwd", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 6'd0);

        // stall counter saturation: lw x5,0(x5) repeated
        rst2();
        n = 0;
        for (int i = 0; i < 1000 && n < CMAX + 4; i++) begin
            cyc(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, LD, 1'b0);
            #2;
            if (StallD === 1'b1) n++;
        end
        chk("sat_stall_cycles", n, CMAX + 4);
        nop(); #2;
        chk("sat_stallCnt", StallCnt, CMAX);

        // randomized traffic
        rst2();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] src;
            src = ($urandom_range(0, 2) == 0) ? LD : 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 199) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), src,
                ($urandom_range(0, 9) == 0));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
